// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC rotator arbiter and the FFT
// butterfly scheduler.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int DATA_W_DEF = 16;
    localparam int PHI_W_DEF  = 16;

    // W^0 twiddle: the rotation is identity, so the core is skipped.
    localparam logic [15:0] PHI_ZERO = 16'h0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping from the top lane back to lane 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_id,
    output logic               o_any
);

    int w_idx;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(i_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/cordic_rotator_arbiter.sv
// Shares one iterative CORDIC rotator between butterfly lanes: round-robin
// accept, launch, watchdog-guarded wait, tagged response. W^0 bypasses the core.
module cordic_rotator_arbiter
    import cordic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PHI_W   = PHI_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_x,
    input  logic [NUM_REQ*DATA_W-1:0]    req_y,
    input  logic [NUM_REQ*PHI_W-1:0]     req_phi,
    output logic                         core_start,
    output logic [DATA_W-1:0]            core_x,
    output logic [DATA_W-1:0]            core_y,
    output logic [PHI_W-1:0]             core_phi,
    input  logic                         core_done,
    input  logic [DATA_W-1:0]            core_x_res,
    input  logic [DATA_W-1:0]            core_y_res,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [DATA_W-1:0]            resp_x,
    output logic [DATA_W-1:0]            resp_y,
    output logic                         resp_err,
    output logic                         busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_rr;
    logic [ID_W-1:0]     r_id;
    logic [WD_W-1:0]     r_wd;
    logic [DATA_W-1:0]   r_core_x;
    logic [DATA_W-1:0]   r_core_y;
    logic [PHI_W-1:0]    r_core_phi;
    logic [DATA_W-1:0]   r_resp_x;
    logic [DATA_W-1:0]   r_resp_y;
    logic                r_resp_err;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_gnt_id;
    logic                w_any;
    logic [ID_W-1:0]     w_rr_next;
    logic [DATA_W-1:0]   w_sel_x;
    logic [DATA_W-1:0]   w_sel_y;
    logic [PHI_W-1:0]    w_sel_phi;
    logic                w_bypass;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_rr),
        .o_grant (w_grant),
        .o_id    (w_gnt_id),
        .o_any   (w_any)
    );

    assign w_sel_x   = req_x[w_gnt_id*DATA_W +: DATA_W];
    assign w_sel_y   = req_y[w_gnt_id*DATA_W +: DATA_W];
    assign w_sel_phi = req_phi[w_gnt_id*PHI_W +: PHI_W];
    assign w_bypass  = (w_sel_phi == PHI_W'(PHI_ZERO));
    assign w_rr_next = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

    // Accept strobe is only offered from IDLE, so a stalled response blocks all lanes.
    assign req_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
    assign core_start = (r_state == ISSUE);
    assign resp_valid = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign core_x     = r_core_x;
    assign core_y     = r_core_y;
    assign core_phi   = r_core_phi;
    assign resp_id    = r_id;
    assign resp_x     = r_resp_x;
    assign resp_y     = r_resp_y;
    assign resp_err   = r_resp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr       <= '0;
            r_id       <= '0;
            r_wd       <= '0;
            r_core_x   <= '0;
            r_core_y   <= '0;
            r_core_phi <= '0;
            r_resp_x   <= '0;
            r_resp_y   <= '0;
            r_resp_err <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id <= w_gnt_id;
                        r_rr <= w_rr_next;
                        if (w_bypass) begin
                            r_resp_x   <= w_sel_x;
                            r_resp_y   <= w_sel_y;
                            r_resp_err <= 1'b0;
                            r_state    <= RESP;
                        end else begin
                            r_core_x   <= w_sel_x;
                            r_core_y   <= w_sel_y;
                            r_core_phi <= w_sel_phi;
                            r_state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_wd    <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A done pulse on the final watchdog cycle still counts as success.
                    if (core_done) begin
                        r_resp_x   <= core_x_res;
                        r_resp_y   <= core_y_res;
                        r_resp_err <= 1'b0;
                        r_state    <= RESP;
                    end else if (r_wd == WD_LAST) begin
                        r_resp_x   <= '0;
                        r_resp_y   <= '0;
                        r_resp_err <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cordic_rotator_arbiter.md
Name: cordic_rotator_arbiter

Overview:
- Shares one iterative CORDIC rotator core between NUM_REQ butterfly lanes of the FFT datapath.
- Arbitrates lane requests round-robin and launches the core with a one-cycle start pulse.
- Waits for the core's done pulse, with a watchdog, then returns the rotated pair tagged with the lane id over a valid/ready response channel.
- Twiddle angle 0 (W^0) bypasses the core entirely.

Parameters:
- NUM_REQ, 4, number of requesting lanes (≥2).
- DATA_W, 16, signed sample width, Q1.15.
- PHI_W, 16, twiddle angle width, same scaling as the core's angle input.
- TIMEOUT, 64, maximum cycles waited for core_done before flagging an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-lane request valid.
- req_ready  out  NUM_REQ  per-lane accept. One-hot or zero.
- req_x  in  NUM_REQ*DATA_W  per-lane x operands, packed, lane 0 in LSBs.
- req_y  in  NUM_REQ*DATA_W  per-lane y operands, packed.
- req_phi  in  NUM_REQ*PHI_W  per-lane twiddle angles, packed.
- core_start  out  1  one-cycle launch pulse to the CORDIC core.
- core_x  out  DATA_W  latched x operand to the core.
- core_y  out  DATA_W  latched y operand to the core.
- core_phi  out  PHI_W  latched angle to the core.
- core_done  in  1  core result-valid pulse.
- core_x_res  in  DATA_W  core rotated x (gain-compensated).
- core_y_res  in  DATA_W  core rotated y.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  $clog2(NUM_REQ)  lane id of the response.
- resp_x  out  DATA_W  result x.
- resp_y  out  DATA_W  result y.
- resp_err  out  1  response produced by watchdog timeout.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (clk edge with rst=1):
  - FSM to IDLE; rr pointer to 0; watchdog counter to 0.
  - All outputs 0: req_ready, core_start, core_x/y/phi, resp_valid, resp_id, resp_x/y, resp_err, busy.
  - Reset mid-operation drops the in-flight op with no response. The core shares rst.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first lane with req_valid, searching from rr upward with wrap (NUM_REQ-1 → 0).
  - req_ready[grant] is high combinationally in that same cycle, only while in IDLE; the transfer completes on that edge.
  - On accept: latch the operands and grant id; rr ← (grant+1) mod NUM_REQ.
  - If the latched phi == 0: load resp_x/y = x/y directly, resp_err=0, go to RESP (bypass, core untouched).
  - Otherwise go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE: core_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - core_done=1: capture core_x_res/core_y_res into resp_x/y, resp_err=0, go to RESP.
  - Else, watchdog reaching TIMEOUT-1: resp_x/y=0, resp_err=1, go to RESP.
  - core_done and timeout on the same cycle: core_done wins.
- RESP:
  - resp_valid=1 with resp_id, resp_x, resp_y, resp_err held stable until resp_ready.
  - On the resp_valid&&resp_ready edge: go to IDLE.
  - resp_ready held 0 stalls indefinitely; no new request is accepted while stalled.
- Latency, core op with core latency L (core_done L cycles after core_start):
  - Accept edge = cycle 0; core_start at cycle 1; resp_valid first high at cycle L+2.
  - With resp_ready=1, the next accept is possible at cycle L+3.
- Latency, bypass: resp_valid at cycle 1; next accept at cycle 2.
- core_done arriving outside WAIT is ignored.
- Requesters may drop req_valid before accept; lanes not accepted see no side effect.
- Operands latch unmodified, with no width growth. The block does no arithmetic on data.
- One op in flight at a time; no buffering beyond the single response register.

Decomposition:
- Shared package cordic_pkg:
  - FSM state enum arb_state_t (IDLE, ISSUE, WAIT, RESP).
  - DATA_W/PHI_W default constants.
  - Q1.15 constant PHI_ZERO.
- Sub-module rr_arbiter:
  - Parameterised NUM_REQ round-robin priority picker.
  - Inputs: req vector, rr pointer. Outputs: one-hot grant, encoded id, any.
  - Purely combinational, reused by the later butterfly scheduler.

Test Plan:
- Single request, stub core L=8: lane 2 requests x=0x4000, y=0, phi=0x3244 → req_ready[2] at cycle 0, core_start at cycle 1, core_done with x_res=0x2D41, y_res=0x2D41 → resp_valid at cycle 10, resp_id=2, resp_x=0x2D41, resp_err=0.
- Fairness: all 4 lanes hold req_valid continuously, resp_ready=1 → grant order 0,1,2,3,0,1; no lane is granted twice before the others.
- Bypass: lane 1 phi=0, x=0x1234, y=0xEDCC → resp_valid at cycle 1 with the same x/y; core_start never asserted.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid → outputs stable, req_ready stays 0 for all lanes, busy=1; the release accepts the next request in the following IDLE cycle.
- Watchdog: core never asserts core_done, TIMEOUT=64 → resp_valid with resp_err=1, resp_x/y=0; a core_done landing on the timeout cycle gives resp_err=0.
- Reset mid-WAIT: rst for 1 cycle → busy=0, resp_valid=0, no response for the dropped op, rr=0; the next request from lane 3 (with lane 0 also valid) grants lane 0 first.
